// File: rtl/divider_arbiter_if.sv
// Bundle of requester, divider and result signals shared by the round-robin divider arbiter.
// The slave modport is the arbiter's view; master is the surrounding system (requesters plus divider).
interface divider_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int N       = 5,
  parameter int M       = 3
) ();

  logic                 issue_en;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_dividend;
  logic [NUM_REQ*M-1:0] req_divisor;

  logic                 div_data_rdy;
  logic [N-1:0]         div_dividend;
  logic [M-1:0]         div_divisor;
  logic                 div_res_rdy;
  logic [N-1:0]         div_merchant;
  logic [M-1:0]         div_remainder;

  logic [NUM_REQ-1:0]   res_valid;
  logic [N-1:0]         res_merchant;
  logic [M-1:0]         res_remainder;
  logic                 res_div0;
  logic                 busy;
  logic                 err_sticky;

  modport master (
    output issue_en, req_valid, req_dividend, req_divisor,
    output div_res_rdy, div_merchant, div_remainder,
    input  req_ready, div_data_rdy, div_dividend, div_divisor,
    input  res_valid, res_merchant, res_remainder, res_div0, busy, err_sticky
  );

  modport slave (
    input  issue_en, req_valid, req_dividend, req_divisor,
    input  div_res_rdy, div_merchant, div_remainder,
    output req_ready, div_data_rdy, div_dividend, div_divisor,
    output res_valid, res_merchant, res_remainder, res_div0, busy, err_sticky
  );

endinterface

// File: rtl/divider_arbiter.sv
// Round-robin scheduler sharing one pipelined divider among NUM_REQ requesters; a tag pipe
// returns every result to its originator in issue order and flags divide-by-zero and protocol errors.
module divider_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int N       = 5,
  parameter int M       = 3,
  parameter int LAT     = 5,
  parameter int ID_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  divider_arbiter_if.slave bus
);

  localparam int              CNT_W     = $clog2(LAT + 2);
  localparam logic [CNT_W-1:0] FLUSH_LEN = CNT_W'(LAT + 1);
  localparam logic [ID_W-1:0]  PTR_RST   = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]    rrPtr_q, rrPtr_d;
  logic [ID_W-1:0]    hiId, loId, winnerId;
  logic               foundHi, foundLo, grant;
  logic [NUM_REQ-1:0] reqReady;
  logic [N-1:0]       selDividend;
  logic [M-1:0]       selDivisor;

  logic               issueValid_q, issueDz_q;
  logic [ID_W-1:0]    issueId_q;
  logic [N-1:0]       divDividend_q;
  logic [M-1:0]       divDivisor_q;

  logic [LAT-1:0]     tagV_q, tagDz_q;
  logic [ID_W-1:0]    tagId_q [LAT];

  logic [CNT_W-1:0]   flushCnt_q;
  logic               flushing, protoErr;

  logic [NUM_REQ-1:0] resValid_q, resValid_d;
  logic [N-1:0]       resMerchant_q, resMerchant_d;
  logic [M-1:0]       resRemainder_q, resRemainder_d;
  logic               resDiv0_q, resDiv0_d;
  logic               errSticky_q, errSticky_d;

  // Requesters above the pointer take precedence over those at or below it, giving an upward search with wrap.
  always_comb begin
    foundHi     = 1'b0;
    foundLo     = 1'b0;
    hiId        = '0;
    loId        = '0;
    selDividend = '0;
    selDivisor  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (bus.req_valid[k]) begin
        if (ID_W'(k) > rrPtr_q) begin
          if (!foundHi) begin
            foundHi = 1'b1;
            hiId    = ID_W'(k);
          end
        end else if (!foundLo) begin
          foundLo = 1'b1;
          loId    = ID_W'(k);
        end
      end
    end
    winnerId = foundHi ? hiId : loId;
    grant    = bus.issue_en && !reset && (foundHi || foundLo);
    reqReady = '0;
    if (grant) begin
      reqReady = NUM_REQ'(1) << winnerId;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == winnerId) begin
        selDividend = bus.req_dividend[k*N +: N];
        selDivisor  = bus.req_divisor[k*M +: M];
      end
    end
    rrPtr_d = grant ? winnerId : rrPtr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr_q       <= PTR_RST;
      issueValid_q  <= 1'b0;
      issueId_q     <= '0;
      issueDz_q     <= 1'b0;
      divDividend_q <= '0;
      divDivisor_q  <= '0;
    end else begin
      rrPtr_q      <= rrPtr_d;
      issueValid_q <= grant;
      if (grant) begin
        issueId_q     <= winnerId;
        issueDz_q     <= (selDivisor == '0);
        divDividend_q <= selDividend;
        divDivisor_q  <= selDivisor;
      end
    end
  end

  // The tag pipe is fed from the issue register so its tail lines up with the divider's result strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      tagV_q  <= '0;
      tagDz_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        tagId_q[k] <= '0;
      end
    end else begin
      tagV_q[0]  <= issueValid_q;
      tagDz_q[0] <= issueDz_q;
      tagId_q[0] <= issueId_q;
      for (int k = 1; k < LAT; k++) begin
        tagV_q[k]  <= tagV_q[k-1];
        tagDz_q[k] <= tagDz_q[k-1];
        tagId_q[k] <= tagId_q[k-1];
      end
    end
  end

  // Reset loads the window length: the divider is not reset with us and may emit stale strobes meanwhile.
  always_ff @(posedge clk) begin
    if (reset) begin
      flushCnt_q <= FLUSH_LEN;
    end else if (flushing) begin
      flushCnt_q <= flushCnt_q - CNT_W'(1);
    end
  end

  assign flushing = (flushCnt_q != '0);
  assign protoErr = !flushing && (bus.div_res_rdy != tagV_q[LAT-1]);

  always_comb begin
    resValid_d     = '0;
    resMerchant_d  = resMerchant_q;
    resRemainder_d = resRemainder_q;
    resDiv0_d      = resDiv0_q;
    errSticky_d    = errSticky_q | protoErr;
    if (tagV_q[LAT-1]) begin
      resValid_d = NUM_REQ'(1) << tagId_q[LAT-1];
      if (tagDz_q[LAT-1]) begin
        resMerchant_d  = '1;
        resRemainder_d = '0;
        resDiv0_d      = 1'b1;
      end else begin
        resMerchant_d  = bus.div_merchant;
        resRemainder_d = bus.div_remainder;
        resDiv0_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resValid_q     <= '0;
      resMerchant_q  <= '0;
      resRemainder_q <= '0;
      resDiv0_q      <= 1'b0;
      errSticky_q    <= 1'b0;
    end else begin
      resValid_q     <= resValid_d;
      resMerchant_q  <= resMerchant_d;
      resRemainder_q <= resRemainder_d;
      resDiv0_q      <= resDiv0_d;
      errSticky_q    <= errSticky_d;
    end
  end

  assign bus.req_ready     = reqReady;
  assign bus.div_data_rdy  = issueValid_q;
  assign bus.div_dividend  = divDividend_q;
  assign bus.div_divisor   = divDivisor_q;
  assign bus.res_valid     = resValid_q;
  assign bus.res_merchant  = resMerchant_q;
  assign bus.res_remainder = resRemainder_q;
  assign bus.res_div0      = resDiv0_q;
  assign bus.err_sticky    = errSticky_q;
  assign bus.busy          = issueValid_q | (|tagV_q) | (|resValid_q);

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter: a behavioural pipelined divider sits on the divider port and a
// scoreboard queue holds the expected result, originator and arrival cycle of every granted request.
module tb_divider_arbiter;

  localparam int NUM_REQ = 4;
  localparam int N       = 5;
  localparam int M       = 3;
  localparam int LAT     = 5;
  localparam int ID_W    = 2;

  typedef struct {
    int                 due;
    logic [NUM_REQ-1:0] who;
    logic [N-1:0]       q;
    logic [M-1:0]       r;
    logic               dz;
  } exp_t;

  logic clk;
  logic reset;
  logic forceRdy;
  int   compared;
  int   mismatched;
  int   cyc;
  int   rrExp;
  int   opA [NUM_REQ];
  int   opB [NUM_REQ];
  exp_t sb [$];

  divider_arbiter_if #(.NUM_REQ(NUM_REQ), .N(N), .M(M)) ifc ();

  divider_arbiter #(
    .NUM_REQ(NUM_REQ), .N(N), .M(M), .LAT(LAT), .ID_W(ID_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural divider: never reset, returns garbage for a zero divisor.
  logic [LAT-1:0] mV = '0;
  logic [N-1:0]   mQ [LAT];
  logic [M-1:0]   mR [LAT];

  always @(posedge clk) begin
    mV[0] <= ifc.div_data_rdy;
    mQ[0] <= (ifc.div_divisor == '0) ? N'(7) : ifc.div_dividend / N'(ifc.div_divisor);
    mR[0] <= (ifc.div_divisor == '0) ? M'(5) : M'(ifc.div_dividend % N'(ifc.div_divisor));
    for (int k = 1; k < LAT; k++) begin
      mV[k] <= mV[k-1];
      mQ[k] <= mQ[k-1];
      mR[k] <= mR[k-1];
    end
  end

  assign ifc.div_res_rdy   = mV[LAT-1] | forceRdy;
  assign ifc.div_merchant  = mQ[LAT-1];
  assign ifc.div_remainder = mR[LAT-1];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [NUM_REQ-1:0] v);
    ifc.issue_en  = en;
    ifc.req_valid = v;
    #1;
  endtask

  task automatic setOp(input int k, input int a, input int b);
    opA[k] = a;
    opB[k] = b;
    ifc.req_dividend[k*N +: N] = N'(a);
    ifc.req_divisor[k*M +: M]  = M'(b);
  endtask

  // One clock: record handshakes, advance, then check whatever result the DUT presents.
  task automatic cycle();
    exp_t               e;
    logic [NUM_REQ-1:0] hs;
    #1;
    hs = ifc.req_valid & ifc.req_ready;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (hs[k]) begin
        e.due = cyc + LAT + 2;
        e.who = NUM_REQ'(1) << k;
        if (opB[k] == 0) begin
          e.q  = '1;
          e.r  = '0;
          e.dz = 1'b1;
        end else begin
          e.q  = N'(opA[k] / opB[k]);
          e.r  = M'(opA[k] % opB[k]);
          e.dz = 1'b0;
        end
        sb.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (ifc.res_valid != '0) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_res_valid", 32'(ifc.res_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("res_cycle", 32'(cyc), 32'(e.due));
        checkOutput("res_valid", 32'(ifc.res_valid), 32'(e.who));
        checkOutput("res_merchant", 32'(ifc.res_merchant), 32'(e.q));
        checkOutput("res_remainder", 32'(ifc.res_remainder), 32'(e.r));
        checkOutput("res_div0", 32'(ifc.res_div0), 32'(e.dz));
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checkOutput("missing_result", 32'(ifc.res_valid), 32'(e.who));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    forceRdy   = 1'b0;
    reset      = 1'b1;
    ifc.req_dividend = '0;
    ifc.req_divisor  = '0;
    for (int k = 0; k < NUM_REQ; k++) setOp(k, 0, 1);
    applyStimulus(1'b1, 4'b1111);

    $display("[TB] reset");
    checkOutput("ready_in_reset", 32'(ifc.req_ready), 32'd0);
    idle(2);
    checkOutput("rst_res_valid", 32'(ifc.res_valid), 32'd0);
    checkOutput("rst_data_rdy", 32'(ifc.div_data_rdy), 32'd0);
    checkOutput("rst_busy", 32'(ifc.busy), 32'd0);
    checkOutput("rst_err", 32'(ifc.err_sticky), 32'd0);
    applyStimulus(1'b1, 4'b0000);
    reset = 1'b0;

    $display("[TB] single op");
    setOp(0, 13, 3);
    applyStimulus(1'b1, 4'b0001);
    checkOutput("single_ready", 32'(ifc.req_ready), 32'b0001);
    cycle();
    applyStimulus(1'b1, 4'b0000);
    checkOutput("single_data_rdy", 32'(ifc.div_data_rdy), 32'd1);
    checkOutput("single_dividend", 32'(ifc.div_dividend), 32'd13);
    checkOutput("single_divisor", 32'(ifc.div_divisor), 32'd3);
    checkOutput("single_busy", 32'(ifc.busy), 32'd1);
    idle(LAT + 3);
    rrExp = 0;

    $display("[TB] full contention");
    setOp(0, 13, 3);
    setOp(1, 22, 5);
    setOp(2, 31, 7);
    setOp(3, 9, 2);
    applyStimulus(1'b1, 4'b1111);
    for (int i = 0; i < 8; i++) begin
      rrExp = (rrExp + 1) % NUM_REQ;
      checkOutput("rr_grant", 32'(ifc.req_ready), 32'(1 << rrExp));
      cycle();
    end
    applyStimulus(1'b1, 4'b0000);
    idle(LAT + 3);

    $display("[TB] divide by zero");
    setOp(2, 9, 0);
    applyStimulus(1'b1, 4'b0100);
    checkOutput("dz_ready", 32'(ifc.req_ready), 32'b0100);
    cycle();
    applyStimulus(1'b1, 4'b0000);
    idle(LAT + 3);
    checkOutput("dz_err", 32'(ifc.err_sticky), 32'd0);
    setOp(2, 31, 7);

    $display("[TB] drain");
    applyStimulus(1'b1, 4'b1111);
    idle(3);
    applyStimulus(1'b0, 4'b1111);
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      checkOutput("drain_ready", 32'(ifc.req_ready), 32'd0);
      cycle();
    end
    checkOutput("drain_outstanding", 32'(sb.size()), 32'd0);
    checkOutput("busy_last_result", 32'(ifc.busy), 32'd1);
    cycle();
    checkOutput("busy_after_drain", 32'(ifc.busy), 32'd0);
    applyStimulus(1'b1, 4'b0000);

    $display("[TB] reset mid-flight");
    applyStimulus(1'b1, 4'b0111);
    idle(3);
    applyStimulus(1'b1, 4'b0000);
    sb.delete();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkOutput("midrst_res_valid", 32'(ifc.res_valid), 32'd0);
    checkOutput("midrst_busy", 32'(ifc.busy), 32'd0);
    idle(LAT + 3);
    checkOutput("flush_err", 32'(ifc.err_sticky), 32'd0);
    setOp(0, 27, 4);
    setOp(1, 22, 5);
    applyStimulus(1'b1, 4'b0011);
    checkOutput("post_rst_ready0", 32'(ifc.req_ready), 32'b0001);
    cycle();
    applyStimulus(1'b1, 4'b0010);
    checkOutput("post_rst_ready1", 32'(ifc.req_ready), 32'b0010);
    cycle();
    applyStimulus(1'b1, 4'b0000);
    idle(LAT + 3);
    checkOutput("post_rst_outstanding", 32'(sb.size()), 32'd0);

    $display("[TB] protocol error");
    forceRdy = 1'b1;
    cycle();
    forceRdy = 1'b0;
    checkOutput("proto_err_set", 32'(ifc.err_sticky), 32'd1);
    idle(3);
    checkOutput("proto_err_hold", 32'(ifc.err_sticky), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkOutput("proto_err_cleared", 32'(ifc.err_sticky), 32'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
Round-robin scheduler that shares one pipelined divider_man instance (N-bit dividend, M-bit divisor, one issue per cycle, no backpressure) between NUM_REQ requesters. It grants at most one request per cycle and drives the divider's issue port. A tag pipeline tracks the requester ID of every in-flight operation, so each result is returned to its originator in issue order. It also flags divide-by-zero and divider protocol errors.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
N, 5, dividend width; also merchant width
M, 3, divisor and remainder width
LAT, 5, divider latency in cycles from data_rdy sampled to res_rdy; equals N for divider_man
ID_W, 2, requester ID width, >= clog2(NUM_REQ)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
issue_en  in  1  global issue enable; 0 = grant nothing, let the pipeline drain
req_valid  in  NUM_REQ  per-requester request
req_ready  out  NUM_REQ  one-hot grant, combinational, same cycle as req_valid
req_dividend  in  NUM_REQ*N  packed; requester k uses bits [k*N +: N]
req_divisor  in  NUM_REQ*M  packed; requester k uses bits [k*M +: M]
div_data_rdy  out  1  divider issue strobe (registered)
div_dividend  out  N  divider operand (registered)
div_divisor  out  M  divider operand (registered)
div_res_rdy  in  1  divider result strobe
div_merchant  in  N  divider quotient
div_remainder  in  M  divider remainder
res_valid  out  NUM_REQ  one-hot result strobe (registered)
res_merchant  out  N  result quotient
res_remainder  out  M  result remainder
res_div0  out  1  current result had divisor==0
busy  out  1  at least one operation in flight, or issue registers occupied
err_sticky  out  1  divider protocol error seen; cleared only by reset

Behaviour:
- Reset (synchronous, active-high): all outputs go to 0 in the next cycle. Also cleared: the RR pointer (resets to NUM_REQ-1, so requester 0 wins first), tag pipe, flush counter and err_sticky.
- Arbitration:
  - A grant is made only when issue_en=1 and reset=0.
  - The winner is the first valid requester after the RR pointer, searching upward with wrap.
  - req_ready[k]=1 for the winner only. The pointer moves to the winner on a grant and holds otherwise.
  - A handshake is req_valid[k] && req_ready[k]. Requesters must hold operands stable while valid is high.
- Issue stage, handshake at cycle t:
  - In cycle t+1: div_data_rdy=1, div_dividend and div_divisor carry the winner's operands.
  - With no grant: div_data_rdy=0 and the operands hold their last values.
  - A zero divisor is still issued, keeping the tag pipe aligned.
- Tag pipe:
  - LAT-deep shift register of {v, id[ID_W-1:0], dz}, loaded in step with div_data_rdy.
  - The tail reaches its output in cycle t+1+LAT, aligned with div_res_rdy.
- Result stage, registered, cycle t+2+LAT:
  - res_valid = one-hot(tail.id) when tail.v=1.
  - Normal case (dz=0): res_merchant=div_merchant, res_remainder=div_remainder, res_div0=0.
  - Divide-by-zero (dz=1): res_merchant=all ones, res_remainder=0, res_div0=1. The divider output is ignored.
  - When no result: res_valid=0 and data holds.
- Total latency from handshake to res_valid is LAT+2 cycles. Throughput is 1 per cycle. Results emerge in global issue order.
- Protocol check:
  - Error when div_res_rdy != tail.v.
  - On error: err_sticky <= 1. Any tail.v result is still delivered.
  - A spurious div_res_rdy with tail.v=0 is dropped.
- Flush window:
  - After reset deasserts, a counter runs for LAT+1 cycles. The divider may still emit stale results in this window.
  - Mismatches in this window are suppressed: no error, no delivery.
  - Grants are permitted during the window.
- Busy: busy = div_data_rdy OR any tag v OR res_valid pending.
- Reset mid-flight: all in-flight operations are discarded and no result is delivered for them.
- issue_en falling mid-stream: operations already granted complete normally.

Test Plan:
- Single op: NUM_REQ=4, N=5, M=3, LAT=5; req_valid=0001, dividend 13, divisor 3 at cycle 0 -> req_ready=0001 at cycle 0; div_data_rdy at cycle 1; res_valid=0001 at cycle 7 with merchant 4, remainder 1, res_div0=0.
- Full contention: req_valid=1111 held, distinct operands -> grants 0,1,2,3,0,... one per cycle; res_valid sequence 0001,0010,0100,1000 from cycle 7 onward, each value correct.
- Divide by zero: requester 2 sends dividend 9, divisor 0 -> res_valid=0100 at cycle 7; merchant 31, remainder 0, res_div0=1; err_sticky stays 0.
- Drain: three ops in flight, then issue_en=0 with req_valid=1111 -> req_ready=0000; the three results are delivered; busy falls the cycle after the last res_valid.
- Reset mid-flight: three ops in flight, reset for 1 cycle, divider not reset and emitting stale res_rdy -> res_valid stays 0 and err_sticky stays 0 through the flush window; a fresh op after reset returns correctly.
- Protocol error: after the flush window, force div_res_rdy=1 with an empty tag pipe -> err_sticky=1 next cycle and held until reset; nothing delivered.
